// File: rtl/nes_mem_pkg.sv
// Shared types and defaults for the N-channel NES memory arbiter.
// Imported by the arbiter top; holds the FSM encoding and widths.
package nes_mem_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_OP
    } state_e;

    localparam int LATENCY_DEF = 4;
    localparam int ADDR_W_DEF  = 22;
    localparam int DATA_W_DEF  = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Produces a one-hot grant, its index and a valid flag.
module rr_pick #(
    parameter int NCH = 4,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [PW-1:0]  idx_o,
    output logic           valid_o
);

    always_comb begin
        int j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan from the far end so the nearest offset to ptr wins last.
        for (int k = NCH - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NCH;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel byte request arbiter in front of the SDRAM driver.
// Per-channel pending slots, refresh-first round-robin issue.
module mem_arbiter_nch
    import nes_mem_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      req_rd,
    input  logic [NCH-1:0]      req_wr,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*DATA_W-1:0] req_din,
    output logic [NCH*DATA_W-1:0] dout,
    output logic [NCH-1:0]      ack,
    output logic [NCH-1:0]      pending,
    input  logic                refresh,
    output logic [ADDR_W:0]     mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                mem_refresh,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout,
    input  logic                mem_busy,
    input  logic                mem_data_ready,
    output logic                ready,
    output logic                fail
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [NCH-1:0]               pending_q, pending_d;
    logic [NCH-1:0][ADDR_W-1:0]   addr_q;
    logic [NCH-1:0][DATA_W-1:0]   din_q;
    logic [NCH-1:0][DATA_W-1:0]   dout_q;
    logic [NCH-1:0]               wr_q;
    logic [NCH-1:0]               take;
    logic                         req_err;
    logic                         refresh_pend_q;
    logic [PW-1:0]                rr_ptr_q, gnt_idx_q, pick_idx;
    logic                         gnt_ch_q, gnt_wr_q, pick_valid;
    logic [NCH-1:0]               pick_gnt, comp_vec, ack_q;
    logic [ADDR_W-1:0]            sel_addr;
    logic [DATA_W-1:0]            sel_din;
    logic                         sel_wr, lat_hit, comp;
    logic [ADDR_W:0]              mem_addr_q;
    logic [DATA_W-1:0]            mem_din_q;
    logic                         mem_rd_q, mem_wr_q, mem_ref_q;
    logic                         ready_q, fail_q;

    rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
        .req_i  (pending_q),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

    assign lat_hit = (cnt_q == CNT_W'(LATENCY));
    assign comp    = (state_q == ST_OP) && lat_hit && gnt_ch_q;

    always_comb begin
        comp_vec = '0;
        if (comp) comp_vec[gnt_idx_q] = 1'b1;
    end

    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = sel_addr | addr_q[i];
                sel_din  = sel_din | din_q[i];
                sel_wr   = sel_wr | wr_q[i];
            end
        end
    end

    // A completion frees the slot in the same cycle a new request lands.
    always_comb begin
        pending_d = pending_q;
        take      = '0;
        req_err   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (comp_vec[i]) pending_d[i] = 1'b0;
            if (req_rd[i] | req_wr[i]) begin
                if (req_rd[i] & req_wr[i]) req_err = 1'b1;
                if (pending_q[i] & ~comp_vec[i]) begin
                    req_err = 1'b1;
                end else begin
                    take[i]      = 1'b1;
                    pending_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            wr_q      <= '0;
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < NCH; i++) begin
                if (take[i]) begin
                    addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
                    din_q[i]  <= req_din[i*DATA_W +: DATA_W];
                    wr_q[i]   <= req_wr[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT;
            cnt_q          <= '0;
            refresh_pend_q <= 1'b0;
            rr_ptr_q       <= '0;
            gnt_idx_q      <= '0;
            gnt_ch_q       <= 1'b0;
            gnt_wr_q       <= 1'b0;
            ack_q          <= '0;
            dout_q         <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_ref_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_din_q      <= '0;
            ready_q        <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_ref_q <= 1'b0;
            ack_q     <= '0;
            if (req_err) fail_q <= 1'b1;
            if (refresh) refresh_pend_q <= 1'b1;
            unique case (state_q)
                ST_INIT: begin
                    if (!mem_busy) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (refresh_pend_q) begin
                        mem_ref_q      <= 1'b1;
                        refresh_pend_q <= refresh;
                        gnt_ch_q       <= 1'b0;
                        cnt_q          <= CNT_W'(1);
                        state_q        <= ST_OP;
                    end else if (pick_valid) begin
                        mem_addr_q <= {1'b0, sel_addr};
                        mem_din_q  <= sel_din;
                        mem_rd_q   <= ~sel_wr;
                        mem_wr_q   <= sel_wr;
                        gnt_ch_q   <= 1'b1;
                        gnt_wr_q   <= sel_wr;
                        gnt_idx_q  <= pick_idx;
                        rr_ptr_q   <= (pick_idx == PW'(NCH - 1)) ?
                                      '0 : pick_idx + PW'(1);
                        cnt_q      <= CNT_W'(1);
                        state_q    <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (lat_hit) begin
                        state_q <= ST_IDLE;
                        if (gnt_ch_q) begin
                            ack_q[gnt_idx_q] <= 1'b1;
                            if (!gnt_wr_q) begin
                                dout_q[gnt_idx_q] <= mem_dout;
                                if (!mem_data_ready) fail_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign dout        = dout_q;
    assign ack         = ack_q;
    assign pending     = pending_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_refresh = mem_ref_q;
    assign ready       = ready_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Bench for mem_arbiter_nch: issue scoreboard, vector table, corner sequences.
// Driver model returns low address byte XOR 0x16 as read data.
module tb_mem_arbiter_nch;

    localparam int NCH = 4;
    localparam int AW  = 22;
    localparam int DW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NCH-1:0]      req_rd, req_wr, ack, pending;
    logic [NCH*AW-1:0]   req_addr;
    logic [NCH*DW-1:0]   req_din, dout;
    logic                refresh;
    logic [AW:0]         mem_addr;
    logic                mem_rd, mem_wr, mem_refresh;
    logic [DW-1:0]       mem_din, mem_dout;
    logic                mem_busy, mem_data_ready, ready, fail;
    logic [AW:0]         rd_addr_q = '0;

    mem_arbiter_nch dut (
        .clk(clk), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_din(req_din),
        .dout(dout), .ack(ack), .pending(pending),
        .refresh(refresh),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_refresh(mem_refresh), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_busy(mem_busy),
        .mem_data_ready(mem_data_ready),
        .ready(ready), .fail(fail)
    );

    always @(posedge clk) if (mem_rd) rd_addr_q <= mem_addr;
    assign mem_dout = rd_addr_q[7:0] ^ 8'h16;

    typedef struct {
        logic [1:0]    kind;
        logic [AW:0]   addr;
        logic [DW-1:0] din;
    } iss_t;

    typedef struct {
        int            ch;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_dout;
    } vec_t;

    iss_t exp_q[$];
    int   iss_edge[$];
    int   checks = 0, errors = 0, cyc_n = 0, strobes = 0;
    int   ack_edge[NCH], ack_cnt[NCH];
    int   r, c0;
    vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [AW:0] a,
                        input logic [DW-1:0] d);
        iss_t e;
        e.kind = k; e.addr = a; e.din = d;
        exp_q.push_back(e);
    endtask

    task automatic post(input int ch, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (wr) req_wr[ch] = 1'b1;
        else    req_rd[ch] = 1'b1;
        req_addr[ch*AW +: AW] = a;
        req_din[ch*DW +: DW]  = d;
        push(wr ? 2'd2 : 2'd1, {1'b0, a}, wr ? d : '0);
    endtask

    task automatic clr();
        req_rd = '0; req_wr = '0; refresh = 1'b0;
    endtask

    task automatic cyc();
        iss_t e, g;
        @(negedge clk);
        for (int i = 0; i < NCH; i++)
            if (ack[i]) begin ack_edge[i] = cyc_n; ack_cnt[i]++; end
        if (mem_rd | mem_wr | mem_refresh) begin
            strobes++;
            iss_edge.push_back(cyc_n);
            g.kind = mem_refresh ? 2'd3 : (mem_wr ? 2'd2 : 2'd1);
            g.addr = mem_refresh ? '0 : mem_addr;
            g.din  = mem_wr ? mem_din : '0;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL issue: got kind %0d addr %0h, expected none",
                         g.kind, g.addr);
            end else begin
                e = exp_q.pop_front();
                chk("issue kind", 32'(g.kind), 32'(e.kind));
                if (e.kind != 2'd3) chk("issue addr", 32'(g.addr), 32'(e.addr));
                if (e.kind == 2'd2) chk("issue din", 32'(g.din), 32'(e.din));
            end
        end
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic wait_ack(input int ch, input int r0, input int lat,
                            input string nm);
        int  base;
        bit  got;
        base = ack_cnt[ch];
        got  = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            cyc();
            if (ack_cnt[ch] != base) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: ack timeout, got none expected ack", nm);
        end else begin
            chk({nm, " latency"}, 32'(ack_edge[ch] - r0), 32'(lat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{1, 1'b0, 22'h01234A, 8'h00, 8'h5C};
        tv[1] = '{2, 1'b0, 22'h000077, 8'h00, 8'h61};
        tv[2] = '{2, 1'b1, 22'h3FFFFF, 8'hA5, 8'h61};
        tv[3] = '{3, 1'b0, 22'h3FFFFF, 8'h00, 8'hE9};
        tv[4] = '{0, 1'b1, 22'h000000, 8'h3C, 8'h16};
        tv[5] = '{3, 1'b0, 22'h2ABCD0, 8'h00, 8'hC6};
        for (int i = 0; i < NCH; i++) begin ack_cnt[i] = 0; ack_edge[i] = 0; end
        reset = 1'b1; mem_busy = 1'b1; mem_data_ready = 1'b1;
        req_addr = '0; req_din = '0; clr();

        // Init
        cyc(); cyc();
        chk("rst ready", 32'(ready), 0);
        chk("rst pending", 32'(pending), 0);
        chk("rst fail", 32'(fail), 0);
        chk("rst dout", dout, 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst ack", 32'(ack), 0);
        reset = 1'b0;
        post(0, 1'b0, 22'h000100, 8'h00);
        cyc(); clr();
        for (int i = 0; i < 9; i++) cyc();
        chk("init no issue", 32'(strobes), 0);
        chk("init pending", 32'(pending[0]), 1);
        chk("init ready low", 32'(ready), 0);
        mem_busy = 1'b0;
        cyc();
        chk("ready rise", 32'(ready), 1);
        wait_ack(0, cyc_n, 5, "init rd");
        chk("init dout0", 32'(dout[7:0]), 32'h16);

        // Single ops from the vector table
        for (int i = 0; i < 6; i++) begin
            post(tv[i].ch, tv[i].wr, tv[i].addr, tv[i].din);
            cyc(); r = cyc_n; clr();
            wait_ack(tv[i].ch, r, 5, "vec");
            chk("vec dout", 32'(dout[tv[i].ch*DW +: DW]), 32'(tv[i].exp_dout));
            chk("vec pending", 32'(pending[tv[i].ch]), 0);
        end
        chk("vec fail", 32'(fail), 0);

        // Round-robin: two full bursts, both start at channel 0
        for (int b = 0; b < 2; b++) begin
            iss_edge.delete();
            for (int c = 0; c < NCH; c++)
                post(c, 1'b0, 22'(8'h10 + 8'h11 * (c + 4 * b)), 8'h00);
            cyc(); r = cyc_n; clr();
            for (int c = 0; c < NCH; c++) wait_ack(c, r, 5 * (c + 1), "rr");
            chk("rr issues", 32'(iss_edge.size()), NCH);
            if (iss_edge.size() == NCH)
                for (int c = 1; c < NCH; c++)
                    chk("rr spacing", 32'(iss_edge[c] - iss_edge[c-1]), 5);
            for (int c = 0; c < NCH; c++)
                chk("rr dout", 32'(dout[c*DW +: DW]),
                    32'((8'h10 + 8'h11 * (c + 4 * b)) ^ 8'h16));
        end

        // Refresh beats a same-cycle write
        iss_edge.delete();
        push(2'd3, '0, '0);
        post(2, 1'b1, 22'h0055AA, 8'hA5);
        refresh = 1'b1;
        cyc(); r = cyc_n; clr();
        wait_ack(2, r, 10, "ref wr");
        chk("ref issues", 32'(iss_edge.size()), 2);
        if (iss_edge.size() == 2)
            chk("ref spacing", 32'(iss_edge[1] - iss_edge[0]), 5);
        chk("ref dout2", 32'(dout[2*DW +: DW]), 32'h60);

        // Overrun on ch3 while ch0 is in flight
        post(0, 1'b0, 22'h000111, 8'h00);
        cyc(); r = cyc_n; clr();
        cyc();
        post(3, 1'b0, 22'h0A0A0A, 8'h00);
        cyc(); clr();
        cyc();
        req_rd[3] = 1'b1; req_addr[3*AW +: AW] = 22'h0B0B0B;
        cyc(); clr();
        chk("ovr fail", 32'(fail), 1);
        chk("ovr pending3", 32'(pending[3]), 1);
        wait_ack(0, r, 5, "ovr ch0");
        wait_ack(3, r, 10, "ovr ch3");
        chk("ovr dout3", 32'(dout[3*DW +: DW]), 32'h1C);

        // Request lands in the completion cycle of the same channel
        post(1, 1'b0, 22'h000222, 8'h00);
        cyc(); r = cyc_n; clr();
        for (int i = 0; i < 4; i++) cyc();
        post(1, 1'b0, 22'h000333, 8'h00);
        cyc(); clr();
        chk("same ack1", 32'(ack[1]), 1);
        chk("same pending1", 32'(pending[1]), 1);
        wait_ack(1, r, 5, "same first");
        chk("same dout1a", 32'(dout[1*DW +: DW]), 32'h34);
        wait_ack(1, r + 5, 5, "same second");
        chk("same dout1b", 32'(dout[1*DW +: DW]), 32'h25);
        chk("fail sticky", 32'(fail), 1);

        // Reset clears fail; missing data_ready sets it again
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst2 fail", 32'(fail), 0);
        chk("rst2 ready", 32'(ready), 0);
        cyc();
        chk("rst2 ready up", 32'(ready), 1);
        mem_data_ready = 1'b0;
        post(2, 1'b0, 22'h000044, 8'h00);
        cyc(); r = cyc_n; clr();
        wait_ack(2, r, 5, "ndr");
        mem_data_ready = 1'b1;
        chk("ndr fail", 32'(fail), 1);
        chk("ndr dout2", 32'(dout[2*DW +: DW]), 32'h52);
        post(0, 1'b1, 22'h000001, 8'h99);
        cyc(); r = cyc_n; clr();
        wait_ack(0, r, 5, "ndr wr");
        chk("ndr sticky", 32'(fail), 1);

        // Reset while the counter sits at 2
        post(1, 1'b0, 22'h000055, 8'h00);
        cyc(); clr();
        cyc(); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mid pending", 32'(pending), 0);
        chk("mid ready", 32'(ready), 0);
        c0 = ack_cnt[1];
        for (int i = 0; i < 10; i++) cyc();
        chk("mid no ack", 32'(ack_cnt[1] - c0), 0);
        chk("mid pending2", 32'(pending), 0);
        chk("sb empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_nch.md
Name: mem_arbiter_nch

Overview:
- N-channel successor to the single-port NES SDRAM bridge. Sits between the CPU, PPU, DMA and mapper requesters and the `sdram` driver.
- Each channel posts a byte read or write request, which is latched in a per-channel pending slot.
- A round-robin arbiter serialises pending requests onto the driver; refresh has top priority.
- Each channel has its own read-data register and a one-cycle ack pulse, so no requester needs to hold its request.

Parameters:
- NCH, 4, number of requester channels (2..8).
- ADDR_W, 22, byte address width.
- DATA_W, 8, data width per channel.
- LATENCY, 4, cycles from driver strobe to read data valid on mem_dout (≥2).
- CNT_W, 3, width of the operation counter (must hold LATENCY).

Ports:
- clk  in  1  main logic clock
- reset  in  1  synchronous, active-high reset
- req_rd  in  NCH  per-channel read request pulse
- req_wr  in  NCH  per-channel write request pulse
- req_addr  in  NCH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- req_din  in  NCH*DATA_W  packed write data
- dout  out  NCH*DATA_W  per-channel last read data
- ack  out  NCH  one-cycle pulse when channel i's operation completes
- pending  out  NCH  channel i request outstanding
- refresh  in  1  refresh request pulse
- mem_addr  out  ADDR_W+1  driver address, MSB always 0
- mem_rd / mem_wr / mem_refresh  out  1 each  driver strobes, one-cycle pulses
- mem_din  out  DATA_W  driver write data
- mem_dout  in  DATA_W  driver read data
- mem_busy  in  1  driver busy (used during init)
- mem_data_ready  in  1  driver read-valid
- ready  out  1  initialisation complete
- fail  out  1  sticky error flag

Behaviour:

Reset (clk edge with reset=1):
- state=INIT; pending=0; refresh_pend=0; rr_ptr=0.
- ack=0, dout=0, strobes=0, mem_addr=0, mem_din=0, ready=0, fail=0.
- Reset mid-operation aborts the operation silently: no ack is issued, and pending/latched requests are discarded.

Request latch (every cycle, all states including INIT):
- req_rd[i] or req_wr[i] sets pending[i] and captures addr, din and op into slot i.
- If pending[i] is already set and no completion for i happens this cycle, the new request is dropped and fail is set.
- If both req_rd[i] and req_wr[i] are set, the write is taken and fail is set.
- If a request and the completion of the same channel happen in the same cycle, completion clears the old request and the new request is latched (pending stays 1).

Refresh latch:
- refresh sets refresh_pend; repeat pulses while it is set coalesce.

FSM states: INIT, IDLE, OP.
- INIT: requests latch but are not issued. When mem_busy=0, go to IDLE and set ready=1 the next cycle.
- IDLE, issue decision on a clk edge:
  - If refresh_pend: pulse mem_refresh, clear refresh_pend, grant=none.
  - Else if any pending: grant = first set channel scanning rr_ptr, rr_ptr+1, … mod NCH. Drive mem_addr={1'b0, addr[g]}, mem_din=din[g], and pulse mem_rd or mem_wr. Set rr_ptr=(g+1) mod NCH.
  - In both cases set cnt=1 and go to OP.
- OP: strobes=0; cnt increments each cycle. When cnt==LATENCY:
  - For a read grant: dout[g] <= mem_dout, and set fail if mem_data_ready=0.
  - For a channel grant: ack[g]=1 for one cycle, pending[g] cleared.
  - Return to IDLE.

Timing:
- Issue period is LATENCY+1 cycles, i.e. 5 at default.
- Read latency, from the request edge (idle arbiter) to ack, is LATENCY+1 cycles.
- dout[i] holds its value until the next read completes on channel i; writes never alter dout.

Decomposition:
- Shared package: nes_mem_pkg, holding the state enum (INIT/IDLE/OP), the default LATENCY, and the ADDR_W/DATA_W constants.
- One sub-module: rr_pick. It is a combinational round-robin picker (NCH-bit request vector plus pointer in; one-hot grant and index out), tested on its own.

Test Plan:
1. Init: reset 2 cycles, hold mem_busy=1 for 10 cycles then 0 → ready rises 1 cycle later. A req_rd[0] posted during INIT is issued only after ready; mem_rd is not asserted earlier.
2. Single read: ch1 reads 0x1234A, model returns 0x5C at cnt=4 with data_ready=1 → mem_addr=0x01234A, ack[1] 5 cycles after the request, dout[1]=0x5C, fail=0.
3. Round-robin: req_rd on all 4 channels in the same cycle with rr_ptr=0 → grants in order 0,1,2,3 at 5-cycle spacing. A second burst → order resumes at 0 (rr_ptr wrapped).
4. Refresh priority: ch2 write pending and refresh pulse in the same cycle → mem_refresh issued first, ch2 write (din=0xA5) 5 cycles later, and dout[2] unchanged.
5. Overrun: req_rd[3] twice, 2 cycles apart, while ch0 is in OP → fail=1, only the first address is issued. Same-cycle request plus completion on ch1 → pending[1] stays 1 and the new address is issued next.
6. Errors/reset: mem_data_ready=0 at completion → fail=1 (sticky until reset). Reset asserted at cnt=2 → no ack, pending=0, state INIT.
